// File: rtl/button_debounce.sv
// Multi-channel button conditioner: 2-flop synchronizer, stability-window debounce,
// registered edge pulses and a per-channel press auto-repeat FSM.
module button_debounce #(
  parameter int unsigned N_BTN         = 3,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 15000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic [N_BTN-1:0] btn_press
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [19:0] CNT_LAST   = 20'(STABLE_CYCLES - 1);
  localparam logic [26:0] DELAY_END  = 27'(REPEAT_DELAY);
  localparam logic [26:0] PERIOD_END = 27'(REPEAT_PERIOD);

  logic [N_BTN-1:0] s0, s1;
  logic [N_BTN-1:0] level, rise, fall;
  logic [N_BTN-1:0] toggle, rep_pulse;
  logic [19:0]      cnt   [N_BTN];
  logic [26:0]      timer [N_BTN];
  logic [1:0]       state [N_BTN];

  // Repeat pulse is decoded from registered state but gated by the live level and
  // enable, so a release or disable on the terminal-count cycle yields no pulse.
  always_comb begin
    toggle    = '0;
    rep_pulse = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      toggle[i]    = (s1[i] != level[i]) && (cnt[i] == CNT_LAST);
      rep_pulse[i] = level[i] && repeat_en &&
                     (((state[i] == ST_DELAY)  && (timer[i] == DELAY_END)) ||
                      ((state[i] == ST_REPEAT) && (timer[i] == PERIOD_END)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0    <= '0;
      s1    <= '0;
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt[i]   <= '0;
        timer[i] <= '0;
        state[i] <= ST_IDLE;
      end
    end else begin
      s0 <= btn_in;
      s1 <= s0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if ((s1[i] == level[i]) || toggle[i]) cnt[i] <= '0;
        else                                   cnt[i] <= cnt[i] + 20'd1;

        level[i] <= level[i] ^ toggle[i];
        rise[i]  <= toggle[i] && !level[i];
        fall[i]  <= toggle[i] && level[i];

        if (!level[i] || !repeat_en) begin
          state[i] <= ST_IDLE;
          timer[i] <= '0;
        end else begin
          case (state[i])
            ST_IDLE: begin
              if (rise[i]) begin
                state[i] <= ST_DELAY;
                timer[i] <= 27'd1;
              end
            end
            ST_DELAY: begin
              if (timer[i] == DELAY_END) begin
                state[i] <= ST_REPEAT;
                timer[i] <= 27'd1;
              end else begin
                timer[i] <= timer[i] + 27'd1;
              end
            end
            ST_REPEAT: begin
              if (timer[i] == PERIOD_END) timer[i] <= 27'd1;
              else                        timer[i] <= timer[i] + 27'd1;
            end
            default: begin
              state[i] <= ST_IDLE;
              timer[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  assign btn_level = level;
  assign btn_rise  = rise;
  assign btn_fall  = fall;
  assign btn_press = rise | rep_pulse;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus queues hand-computed pulse events,
// a monitor pops and compares one entry whenever any pulse output is active.
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_in;
  logic       repeat_en;
  logic [2:0] btn_level, btn_rise, btn_fall, btn_press;

  int unsigned cyc   = 0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    int unsigned c;
    logic [2:0]  lvl;
    logic [2:0]  r;
    logic [2:0]  f;
    logic [2:0]  p;
  } ev_t;

  ev_t sb[$];

  button_debounce #(
    .N_BTN(3),
    .STABLE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .repeat_en(repeat_en),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .btn_press(btn_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic push(input int unsigned c, input logic [2:0] lvl, input logic [2:0] r,
                      input logic [2:0] f, input logic [2:0] p);
    ev_t e;
    e.c = c; e.lvl = lvl; e.r = r; e.f = f; e.p = p;
    sb.push_back(e);
  endtask

  task automatic go(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: any active pulse is an output event that must match the queue head.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #2;
      if ((btn_rise | btn_fall | btn_press) != 3'b000) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse cyc=%0d got lvl=%b rise=%b fall=%b press=%b expected none",
                   cyc, btn_level, btn_rise, btn_fall, btn_press);
        end else begin
          e = sb.pop_front();
          if (e.c != cyc || e.lvl !== btn_level || e.r !== btn_rise ||
              e.f !== btn_fall || e.p !== btn_press) begin
            bad++;
            $display("FAIL pulse_event got cyc=%0d lvl=%b rise=%b fall=%b press=%b expected cyc=%0d lvl=%b rise=%b fall=%b press=%b",
                     cyc, btn_level, btn_rise, btn_fall, btn_press, e.c, e.lvl, e.r, e.f, e.p);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got timeout expected completion", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int unsigned b, t;
    reset = 1'b1; btn_in = 3'b000; repeat_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {20'd0, btn_level, btn_rise, btn_fall, btn_press}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Clean press on ch0, no repeat: one rise/press at edge 6, then a fall on release
    b = cyc; btn_in[0] = 1'b1;
    push(b + 6, 3'b001, 3'b001, 3'b000, 3'b001);
    go(b + 5);  check("clean_lvl_before", 32'(btn_level), 32'd0);
    go(b + 6);  check("clean_lvl_after", 32'(btn_level), 32'd1);
    go(b + 25); btn_in[0] = 1'b0;
    push(b + 31, 3'b000, 3'b000, 3'b001, 3'b000);
    go(b + 40);

    // Bounce: 3 cycles high, 1 low, then high; window restarts after the glitch
    b = cyc; btn_in[0] = 1'b1;
    push(b + 10, 3'b001, 3'b001, 3'b000, 3'b001);
    go(b + 3); btn_in[0] = 1'b0;
    go(b + 4); btn_in[0] = 1'b1;
    go(b + 6);  check("bounce_lvl_6", 32'(btn_level), 32'd0);
    go(b + 9);  check("bounce_lvl_9", 32'(btn_level), 32'd0);
    go(b + 10); check("bounce_lvl_10", 32'(btn_level), 32'd1);
    go(b + 15); btn_in[0] = 1'b0;
    push(b + 21, 3'b000, 3'b000, 3'b001, 3'b000);
    go(b + 30);

    // Auto-repeat on ch1: T, T+10, T+13, T+16, then release
    b = cyc; repeat_en = 1'b1; btn_in[1] = 1'b1; t = b + 6;
    push(t,      3'b010, 3'b010, 3'b000, 3'b010);
    push(t + 10, 3'b010, 3'b000, 3'b000, 3'b010);
    push(t + 13, 3'b010, 3'b000, 3'b000, 3'b010);
    push(t + 16, 3'b010, 3'b000, 3'b000, 3'b010);
    go(t + 11); btn_in[1] = 1'b0;
    push(t + 17, 3'b000, 3'b000, 3'b010, 3'b000);
    go(t + 40);

    // Release lands on the cycle a repeat would fire: fall only, no press
    b = cyc; btn_in[1] = 1'b1; t = b + 6;
    push(t,      3'b010, 3'b010, 3'b000, 3'b010);
    push(t + 10, 3'b010, 3'b000, 3'b000, 3'b010);
    push(t + 13, 3'b010, 3'b000, 3'b000, 3'b010);
    go(t + 10); btn_in[1] = 1'b0;
    push(t + 16, 3'b000, 3'b000, 3'b010, 3'b000);
    go(t + 30);

    // Drop repeat_en during the hold, re-raise while still held: no more presses
    b = cyc; btn_in[1] = 1'b1; t = b + 6;
    push(t,      3'b010, 3'b010, 3'b000, 3'b010);
    push(t + 10, 3'b010, 3'b000, 3'b000, 3'b010);
    go(t + 10); repeat_en = 1'b0;
    go(t + 16); repeat_en = 1'b1;
    go(t + 30); check("held_lvl", 32'(btn_level), 32'd2);
    go(t + 35); btn_in[1] = 1'b0;
    push(t + 41, 3'b000, 3'b000, 3'b010, 3'b000);
    go(t + 50);

    // Reset while ch2 is held (mid-repeat) and ch0 is mid-count
    b = cyc;
    btn_in[2] = 1'b1;
    push(b + 6, 3'b100, 3'b100, 3'b000, 3'b100);
    go(b + 12); btn_in[0] = 1'b1;
    go(b + 14); reset = 1'b1;
    go(b + 15);
    check("reset_mid_outputs", {20'd0, btn_level, btn_rise, btn_fall, btn_press}, 32'd0);
    reset = 1'b0;
    push(b + 21, 3'b101, 3'b101, 3'b000, 3'b101);
    go(b + 16);
    check("post_reset_outputs", {20'd0, btn_level, btn_rise, btn_fall, btn_press}, 32'd0);
    go(b + 22); btn_in = 3'b000;
    push(b + 28, 3'b000, 3'b000, 3'b101, 3'b000);
    go(b + 45); repeat_en = 1'b0;

    // Identical simultaneous activity on ch0 and ch2 with repeat
    go(cyc + 5);
    b = cyc; repeat_en = 1'b1; btn_in = 3'b101; t = b + 6;
    push(t,      3'b101, 3'b101, 3'b000, 3'b101);
    push(t + 10, 3'b101, 3'b000, 3'b000, 3'b101);
    push(t + 13, 3'b101, 3'b000, 3'b000, 3'b101);
    go(t + 13); btn_in = 3'b000;
    push(t + 16, 3'b101, 3'b000, 3'b000, 3'b101);
    push(t + 19, 3'b000, 3'b000, 3'b101, 3'b000);
    go(t + 30); repeat_en = 1'b0;

    go(cyc + 10);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
